// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Writes a program into RAM before the CPU runs. The control unit reads RAM
//   (fetch, LDA) and writes it through STA; this block is the loader-side
//   writer. It takes a byte stream framed as LEN, LEN data bytes, CHECKSUM.
//   Each data byte is written to RAM addresses 0..LEN-1 in order. The CPU is
//   held in reset until a frame with a good checksum has been loaded.
//
// Parameters
//   N       data / stream byte width
//   ADDR_W  RAM address width
//   DEPTH   maximum program length in bytes (<= 2**ADDR_W)
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   start     one-cycle request to begin a new load (IDLE/DONE/ERR only)
//   in_valid  stream byte valid
//   in_data   stream byte
//   in_ready  loader accepts a byte (LEN/DATA/CSUM)
//   mem_we    RAM write enable, one cycle per data byte
//   mem_addr  RAM write address
//   mem_din   RAM write data
//   cpu_hold  CPU held in reset while 1; drops only when the load succeeds
//   busy      frame in progress (LEN/DATA/CSUM)
//   done      frame loaded and checksum good
//   error     bad length or bad checksum
//   count     data bytes written in the current frame
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int N      = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [N-1:0]      in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [N-1:0]  DEPTH_N = N'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C = (ADDR_W+1)'(1);

  state_t          state;
  logic [N-1:0]    sum;
  logic [N-1:0]    len;
  logic            hs;
  logic [ADDR_W:0] count_inc;
  logic [N-1:0]    sum_next;

  // Length is acceptable only if it is non-zero and fits the RAM.
  function automatic logic len_ok(input logic [N-1:0] l);
    return (l != '0) && (l <= DEPTH_N);
  endfunction

  // Checksum arithmetic is modulo 2**N; the carry is intentionally dropped.
  function automatic logic [N-1:0] add_mod(input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    return a + b;
  endfunction

  assign hs        = in_valid & in_ready;
  assign count_inc = count + ONE_C;
  assign sum_next  = add_mod(sum, in_data);

  // All outputs are registered and updated together with the state, so every
  // flag is a clean function of the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      count    <= '0;
      sum      <= '0;
      len      <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            count    <= '0;
            sum      <= '0;
            len      <= '0;
          end
        end

        S_LEN: begin
          if (hs) begin
            len <= in_data;
            if (len_ok(in_data)) begin
              state <= S_DATA;
            end else begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end
          end
        end

        S_DATA: begin
          if (hs) begin
            // Address is the pre-increment count; count never passes len
            // because the state leaves DATA on the len-th byte.
            sum      <= sum_next;
            mem_we   <= 1'b1;
            mem_addr <= count[ADDR_W-1:0];
            mem_din  <= in_data;
            count    <= count_inc;
            if (N'(count_inc) == len) begin
              state <= S_CSUM;
            end
          end
        end

        S_CSUM: begin
          if (hs) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (sum_next == '0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b0;
        end
      endcase
    end
  end

endmodule
